// File: rtl/syn_fifo_rd_ctrl_pkg.sv
// Shared types for the synchronous-FIFO read-side drain controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package syn_fifo_pkg;

    typedef enum logic [1:0] {
        RDC_IDLE  = 2'd0,
        RDC_RUN   = 2'd1,
        RDC_FLUSH = 2'd2
    } rdc_state_e;

    // Occupancy counter is sized for the largest legal skid depth so that
    // every legal configuration shares one count width.
    localparam int SKID_DEPTH_MAX = 4;
    localparam int SKID_CNT_W     = $clog2(SKID_DEPTH_MAX + 1);

endpackage

// File: rtl/syn_fifo_rd_ctrl_if.sv
// Valid/ready output stream of the read controller.
// Latency: n/a (wiring only).
// Backpressure: consumer drops m_ready; producer holds m_valid/m_data.
interface syn_fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/syn_fifo_rd_ctrl_skid_buf.sv
// Small circular buffer holding words read from the FIFO until the consumer pops them.
// Latency: a pushed word is visible on out_data_o the cycle after the push.
// Backpressure: none internally; the caller never pushes into a full buffer unless it also pops.
module syn_fifo_skid_buf
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [SKID_CNT_W-1:0] count_o
);
    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic                  do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != SKID_CNT_W'(DEPTH)) || do_pop);

    // Pointer and occupancy next-state; clear discards everything, including a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + SKID_CNT_W'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - SKID_CNT_W'(1);
        end
    end

    // Buffer state registers and storage write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign out_data_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;

endmodule

// File: rtl/syn_fifo_rd_ctrl.sv
// Drains the synchronous FIFO onto a valid/ready stream, with a discard-flush mode and a delivered-word counter.
// Latency: m_valid rises 2 cycles after the first rd_o; 1 word/cycle sustained while m_ready=1.
// Backpressure: rd_o is withheld whenever buffered plus in-flight words would exceed SKID_DEPTH.
module syn_fifo_rd_ctrl
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  rd_o,
    output logic                  oe_o,
    syn_fifo_rd_ctrl_if.master    m,
    output logic                  busy_o,
    output logic                  flush_done_o,
    output logic [CNT_WIDTH-1:0]  rd_count_o
);
    localparam int OCC_W = SKID_CNT_W + 1;

    rdc_state_e            state_q, state_d;
    logic                  rd_q;
    logic                  flush_done_q, flush_done_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [SKID_CNT_W-1:0] buf_cnt;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  flush_entry;
    logic                  m_valid, pop, pop_eff, push;
    logic [OCC_W-1:0]      occ;

    // Mode sequencing: flush beats enable; flush exits only once the FIFO and the read pipe are empty.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            RDC_IDLE: begin
                if (flush_i)   state_d = RDC_FLUSH;
                else if (en_i) state_d = RDC_RUN;
            end
            RDC_RUN: begin
                if (flush_i)    state_d = RDC_FLUSH;
                else if (!en_i) state_d = RDC_IDLE;
            end
            RDC_FLUSH: begin
                if (fifo_empty_i && !rd_q && !flush_i) begin
                    state_d      = RDC_IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RDC_IDLE;
        endcase
    end

    assign flush_entry = (state_d == RDC_FLUSH) && (state_q != RDC_FLUSH);

    // Words held in FLUSH are invisible to the consumer; captures during FLUSH are dropped.
    assign m_valid = (state_q != RDC_FLUSH) && (buf_cnt != '0);
    assign pop     = m_valid && m.m_ready;
    assign pop_eff = (state_q == RDC_FLUSH) ? 1'b0 : pop;
    assign push    = rd_q && (state_q != RDC_FLUSH);

    // Room check counts the word already in flight so a stalled consumer cannot overflow the buffer.
    assign occ  = OCC_W'(buf_cnt) + OCC_W'(rd_q) - OCC_W'(pop_eff);
    assign rd_o = ((state_q == RDC_RUN) || (state_q == RDC_FLUSH)) && !fifo_empty_i
                  && (occ < OCC_W'(SKID_DEPTH));

    // Delivered-word counter restarts whenever a flush begins.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_entry) cnt_d = '0;
        else if (pop)    cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // State, read pipe, flush-done pulse and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= RDC_IDLE;
            rd_q         <= 1'b0;
            flush_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_o;
            flush_done_q <= flush_done_d;
            cnt_q        <= cnt_d;
        end
    end

    syn_fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (flush_entry),
        .push_i      (push),
        .push_data_i (fifo_data_i),
        .pop_i       (pop),
        .out_data_o  (buf_data),
        .count_o     (buf_cnt)
    );

    assign oe_o         = rd_q;
    assign m.m_valid    = m_valid;
    assign m.m_data     = buf_data;
    assign busy_o       = (state_q != RDC_IDLE) || rd_q;
    assign flush_done_o = flush_done_q;
    assign rd_count_o   = cnt_q;

endmodule

// File: tb/tb_syn_fifo_rd_ctrl.sv
// Bench for the FIFO read controller: directed vector table, corner-case sequences, randomized scoreboard run.
// Latency: n/a.
// Backpressure: the bench drives m_ready randomly and in held-low phases.
module tb_syn_fifo_rd_ctrl;
    localparam int DW = 16;
    localparam int SD = 2;
    localparam int CW = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk = 1'b0;
    logic          clk_run = 1'b1;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          rd, oe, busy, fd;
    logic [CW-1:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] fq[$];   // contents of the modelled FIFO
    logic [DW-1:0] got[$];  // beats seen on the stream
    logic [DW-1:0] sb[$];   // words still owed to the consumer

    syn_fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

    syn_fifo_rd_ctrl #(
        .DATA_WIDTH (DW),
        .SKID_DEPTH (SD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .flush_i      (flush),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .rd_o         (rd),
        .oe_o         (oe),
        .m            (m_if),
        .busy_o       (busy),
        .flush_done_o (fd),
        .rd_count_o   (cnt)
    );

    always #5 if (clk_run) clk = ~clk;

    // FIFO read side: registered empty flag and data_out, both updated at the edge sampling rd_o.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= '0;
        end else begin
            if (rd) begin
                n_chk++;
                if (fifo_empty) begin
                    n_fail++;
                    $display("FAIL fifo_underflow: rd_o=1 while fifo_empty_i=%0b", fifo_empty);
                end
                if (fq.size() != 0) fifo_data <= fq.pop_front();
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; flush = 1'b0; m_if.m_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic          en, fl, rdy;
        logic          rd, oe, vld;
        logic [DW-1:0] dat;
        logic          busy, fd;
        logic [CW-1:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic e, f, r, erd, eoe, evld, input logic [DW-1:0] d,
                                input logic eb, efd, input logic [CW-1:0] c);
        vec_t v;
        v.en = e; v.fl = f; v.rdy = r; v.rd = erd; v.oe = eoe; v.vld = evld;
        v.dat = d; v.busy = eb; v.fd = efd; v.cnt = c;
        return v;
    endfunction

    vec_t tv [9];

    initial begin
        int nrd, noe, nvld, nfd, first_rd, oe_at, vld_at, outstanding;
        logic [DW-1:0] vdat, prev_dat, w;
        logic stall_prev;
        int unsigned exp_cnt;

        m_if.m_ready = 1'b0;

        // Four-word stream at full rate, one row per cycle starting from IDLE.
        tv[0] = mk(H, L, H, L, L, L, 16'h0000, L, L, 16'd0);
        tv[1] = mk(H, L, H, H, L, L, 16'h0000, H, L, 16'd0);
        tv[2] = mk(H, L, H, H, H, L, 16'h0000, H, L, 16'd0);
        tv[3] = mk(H, L, H, H, H, H, 16'h1111, H, L, 16'd0);
        tv[4] = mk(H, L, H, H, H, H, 16'h2222, H, L, 16'd1);
        tv[5] = mk(H, L, H, L, H, H, 16'h3333, H, L, 16'd2);
        tv[6] = mk(H, L, H, L, L, H, 16'h4444, H, L, 16'd3);
        tv[7] = mk(L, L, H, L, L, L, 16'h0000, H, L, 16'd4);
        tv[8] = mk(L, L, H, L, L, L, 16'h0000, L, L, 16'd4);

        // ---- Streaming table ----
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            en = tv[i].en; flush = tv[i].fl; m_if.m_ready = tv[i].rdy;
            #1;
            chk($sformatf("tbl[%0d].rd", i),   32'(rd),            32'(tv[i].rd));
            chk($sformatf("tbl[%0d].oe", i),   32'(oe),            32'(tv[i].oe));
            chk($sformatf("tbl[%0d].vld", i),  32'(m_if.m_valid),  32'(tv[i].vld));
            if (tv[i].vld) chk($sformatf("tbl[%0d].dat", i), 32'(m_if.m_data), 32'(tv[i].dat));
            chk($sformatf("tbl[%0d].busy", i), 32'(busy),          32'(tv[i].busy));
            chk($sformatf("tbl[%0d].fd", i),   32'(fd),            32'(tv[i].fd));
            chk($sformatf("tbl[%0d].cnt", i),  32'(cnt),           32'(tv[i].cnt));
        end

        // ---- Asynchronous reset mid-stream with the clock stopped ----
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(16'(16'h1111 * (i + 1)));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            en = 1'b1; m_if.m_ready = 1'b1;
            #1;
        end
        chk("rst.pre_vld", 32'(m_if.m_valid), 32'd1);
        chk("rst.pre_cnt", 32'(cnt), 32'd2);
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.rd",   32'(rd),           32'd0);
        chk("rst.oe",   32'(oe),           32'd0);
        chk("rst.vld",  32'(m_if.m_valid), 32'd0);
        chk("rst.busy", 32'(busy),         32'd0);
        chk("rst.fd",   32'(fd),           32'd0);
        chk("rst.cnt",  32'(cnt),          32'd0);
        #2 clk_run = 1'b1;

        // ---- Backpressure: only SKID_DEPTH reads, data held, then lossless release ----
        do_reset();
        for (int i = 0; i < 8; i++) fq.push_back(16'(16'h1111 * (i + 1)));
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            en = 1'b1; m_if.m_ready = 1'b0;
            #1;
            nrd += int'(rd);
            if (m_if.m_valid) chk("bp.hold_dat", 32'(m_if.m_data), 32'h1111);
        end
        chk("bp.nrd", 32'(nrd), 32'(SD));
        chk("bp.rd_low", 32'(rd), 32'd0);
        chk("bp.vld", 32'(m_if.m_valid), 32'd1);
        got.delete();
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            @(negedge clk);
            m_if.m_ready = 1'b1;
            #1;
            if (m_if.m_valid) got.push_back(m_if.m_data);
        end
        chk("bp.beats", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("bp.word[%0d]", i), 32'(got[i]), 32'(16'(16'h1111 * (i + 1))));
        @(negedge clk); #1;
        chk("bp.cnt", 32'(cnt), 32'd8);
        chk("bp.no_extra", 32'(m_if.m_valid), 32'd0);

        // ---- Single word: one read, oe next cycle, one beat ----
        do_reset();
        fq.push_back(16'hA5A5);
        nrd = 0; noe = 0; nvld = 0; first_rd = -1; oe_at = -1; vld_at = -1; vdat = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            en = 1'b1; m_if.m_ready = 1'b1;
            #1;
            if (rd) begin nrd++; if (first_rd < 0) first_rd = c; end
            if (oe) begin noe++; if (oe_at < 0) oe_at = c; end
            if (m_if.m_valid) begin nvld++; if (vld_at < 0) vld_at = c; vdat = m_if.m_data; end
        end
        chk("one.nrd", 32'(nrd), 32'd1);
        chk("one.noe", 32'(noe), 32'd1);
        chk("one.oe_at", 32'(oe_at), 32'(first_rd + 1));
        chk("one.nvld", 32'(nvld), 32'd1);
        chk("one.vld_at", 32'(vld_at), 32'(first_rd + 2));
        chk("one.dat", 32'(vdat), 32'hA5A5);
        chk("one.cnt", 32'(cnt), 32'd1);

        // ---- Flush with 2 words buffered and 5 left in the FIFO ----
        do_reset();
        fq.push_back(16'hBEE0); fq.push_back(16'hBEE1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            en = 1'b1; m_if.m_ready = 1'b1;
            #1;
        end
        chk("fl.pre_cnt", 32'(cnt), 32'd2);
        for (int i = 0; i < 7; i++) fq.push_back(16'(16'hC000 + i));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m_if.m_ready = 1'b0;
            #1;
        end
        chk("fl.pre_vld", 32'(m_if.m_valid), 32'd1);
        chk("fl.pre_dat", 32'(m_if.m_data), 32'hC000);
        chk("fl.pre_left", 32'(fq.size()), 32'd5);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; en = 1'b0; m_if.m_ready = 1'b1;
        #1;
        chk("fl.vld_next", 32'(m_if.m_valid), 32'd0);
        chk("fl.busy", 32'(busy), 32'd1);
        nrd = int'(rd); nvld = 0; nfd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            nrd += int'(rd);
            nvld += int'(m_if.m_valid);
            nfd += int'(fd);
        end
        chk("fl.nrd", 32'(nrd), 32'd5);
        chk("fl.nvld", 32'(nvld), 32'd0);
        chk("fl.done_cycles", 32'(nfd), 32'd1);
        chk("fl.cnt", 32'(cnt), 32'd0);
        chk("fl.idle", 32'(busy), 32'd0);
        chk("fl.fifo_left", 32'(fq.size()), 32'd0);

        // Held flush: no completion pulse until the request drops.
        nfd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            flush = 1'b1;
            #1;
            nfd += int'(fd);
        end
        chk("flh.no_pulse", 32'(nfd), 32'd0);
        chk("flh.busy", 32'(busy), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            flush = 1'b0;
            #1;
            nfd += int'(fd);
        end
        chk("flh.one_pulse", 32'(nfd), 32'd1);
        chk("flh.idle", 32'(busy), 32'd0);

        // ---- Disable in the same cycle as the second read ----
        do_reset();
        for (int i = 0; i < 6; i++) fq.push_back(16'(16'hD000 + i));
        nrd = 0; got.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            m_if.m_ready = 1'b1;
            if (c == 0) en = 1'b1;
            #1;
            if (m_if.m_valid) got.push_back(m_if.m_data);
            if (rd) begin
                nrd++;
                if (nrd == 2) en = 1'b0;
            end
        end
        chk("dis.nrd", 32'(nrd), 32'd2);
        chk("dis.beats", 32'(got.size()), 32'd2);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("dis.word[%0d]", i), 32'(got[i]), 32'(16'(16'hD000 + i)));
        chk("dis.cnt", 32'(cnt), 32'd2);
        chk("dis.idle", 32'(busy), 32'd0);

        // ---- Randomized traffic against a word-order scoreboard ----
        do_reset();
        sb.delete(); exp_cnt = 0; outstanding = 0; stall_prev = 1'b0; prev_dat = '0;
        for (int c = 0; c < 3200; c++) begin
            @(negedge clk);
            if (c < 3000) begin
                if ($urandom_range(0, 2) == 0) begin
                    w = 16'($urandom);
                    fq.push_back(w); sb.push_back(w);
                end
                en = ($urandom_range(0, 7) != 0);
                m_if.m_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                     : ($urandom_range(0, 3) == 0);
            end else begin
                en = 1'b1; m_if.m_ready = 1'b1;
            end
            #1;
            chk("rnd.cnt", 32'(cnt), 32'(16'(exp_cnt)));
            if (stall_prev) begin
                chk("rnd.hold_vld", 32'(m_if.m_valid), 32'd1);
                chk("rnd.hold_dat", 32'(m_if.m_data), 32'(prev_dat));
            end
            if (m_if.m_valid && m_if.m_ready) begin
                if (sb.size() == 0) chk("rnd.spurious_beat", 32'(m_if.m_data), 32'hFFFF_FFFF);
                else chk("rnd.dat", 32'(m_if.m_data), 32'(sb.pop_front()));
                exp_cnt++;
            end
            outstanding = outstanding + int'(rd) - int'(m_if.m_valid && m_if.m_ready);
            if (rd || outstanding > SD) chk("rnd.room", 32'(outstanding <= SD), 32'd1);
            stall_prev = m_if.m_valid && !m_if.m_ready;
            prev_dat = m_if.m_data;
        end
        chk("rnd.all_delivered", 32'(sb.size()), 32'd0);
        @(negedge clk); #1;
        chk("rnd.final_cnt", 32'(cnt), 32'(16'(exp_cnt)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_fifo_rd_ctrl.md
Name: syn_fifo_rd_ctrl

Overview:
Read-side drain controller sitting directly downstream of the synchronous FIFO. It pops words via rd_o/oe_o whenever the FIFO is non-empty and presents them on a valid/ready stream to the consumer, using a small skid buffer so that backpressure never overflows in-flight reads. It also provides a flush mode that empties the FIFO and discards the data, plus a delivered-word counter.

Parameters:
DATA_WIDTH, 16, width of FIFO data and the output stream.
SKID_DEPTH, 2, output buffer entries. Legal values are 2 to 4.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk_i  input  1  single clock, shared with the FIFO read side.
rst_n_i  input  1  reset, asynchronous, active-low.
en_i  input  1  streaming enable.
flush_i  input  1  level request to drain and discard the FIFO. Has priority over en_i.
fifo_empty_i  input  1  FIFO empty flag. Registered; updated at the same edge that samples rd_o.
fifo_data_i  input  DATA_WIDTH  FIFO data_out. Valid in the cycle after rd_o is sampled, while oe_o=1.
rd_o  output  1  FIFO read strobe.
oe_o  output  1  FIFO output enable.
m_valid_o  output  1  output stream valid.
m_data_o  output  DATA_WIDTH  output stream data.
m_ready_i  input  1  output stream ready.
busy_o  output  1  state is not IDLE, or a read is still in flight.
flush_done_o  output  1  one-cycle pulse when a flush completes.
rd_count_o  output  CNT_WIDTH  count of words delivered on the m_* interface.

Behaviour:
- Reset (asynchronous, takes effect with no clock edge):
  - all outputs 0; state IDLE; skid buffer empty; rd_q=0; counter 0.
  - An in-flight read is lost on reset. The FIFO shares this reset.
- FIFO timing: rd_o is sampled at posedge N. The data is captured from fifo_data_i at posedge N+1.
  - rd_q = rd_o registered.
  - oe_o = rd_q, so oe_o is high exactly in the capture cycle.
- Read issue (combinational):
  - pop = m_valid_o & m_ready_i.
  - rd_o = (state is RUN or FLUSH) & !fifo_empty_i & (buf_cnt + rd_q - pop < SKID_DEPTH), where pop is taken as 0 in FLUSH.
  - rd_o is never asserted while fifo_empty_i=1.
- Throughput and latency:
  - Sustains 1 word/cycle while m_ready_i=1.
  - First m_valid_o is asserted 2 cycles after the first rd_o.
- Skid buffer:
  - FIFO order is preserved.
  - Capture and pop in the same cycle are both honoured.
  - m_data_o and m_valid_o are stable while m_valid_o=1 and m_ready_i=0.
- States:
  - IDLE: no reads. flush_i goes to FLUSH (priority); else en_i goes to RUN. Buffered words are still presented and popped.
  - RUN: streaming as above. flush_i goes to FLUSH. If !en_i, go to IDLE: no new rd_o from the following cycle, but the in-flight capture and buffered words are still delivered.
  - FLUSH:
    - On entry the skid buffer is cleared and rd_count_o is reset to 0. m_valid_o=0 throughout.
    - Reads issue every cycle while !fifo_empty_i. Captured data is discarded.
    - Exit when fifo_empty_i=1, rd_q=0 and flush_i=0: pulse flush_done_o for one cycle, then go to IDLE.
    - If flush_i is still high, stay in FLUSH with no further pulse.
- rd_count_o increments by 1 on each pop and wraps modulo 2^CNT_WIDTH. Discarded words are not counted.
- Simultaneous flush_i and en_i: flush wins.
- en_i toggling while a read is in flight: the capture always completes.

Decomposition:
- Package syn_fifo_pkg holds:
  - typedef rdc_state_e {RDC_IDLE, RDC_RUN, RDC_FLUSH};
  - localparam skid count width = $clog2(SKID_DEPTH+1).
- Sub-module syn_fifo_skid_buf holds the SKID_DEPTH-entry circular buffer.
  - Ports: push/push_data, pop/out_data, clear, count.
- The top level holds the FSM, read issue, rd_q/oe_o and the counter.

Test Plan:
1. Reset: hold rst_n_i low mid-stream with the clock stopped -> rd_o, oe_o, m_valid_o, busy_o, flush_done_o and rd_count_o are all 0 immediately.
2. FIFO preloaded with 0x1111, 0x2222, 0x3333, 0x4444; en_i=1; m_ready_i=1 -> rd_o high for 4 consecutive cycles; m_valid_o first high 2 cycles after the first rd_o; data delivered in order; rd_count_o=4; rd_o never high once empty.
3. Backpressure: 8 words preloaded, m_ready_i=0 -> exactly SKID_DEPTH=2 reads, then rd_o stays low and m_data_o holds 0x1111. Release m_ready_i -> the remaining 6 words arrive in order with no loss or duplication; rd_count_o=8.
4. Empty boundary: FIFO holds one word 0xA5A5 -> exactly one rd_o pulse, oe_o high the next cycle, one m_valid_o beat carrying 0xA5A5, and no rd_o while fifo_empty_i=1.
5. Flush: 5 words in the FIFO, 2 already buffered, pulse flush_i -> m_valid_o=0 the next cycle; the FIFO is drained with no m_valid_o; flush_done_o pulses for exactly 1 cycle; rd_count_o=0; state returns to IDLE.
6. Disable mid-stream: deassert en_i the same cycle rd_o is high -> the in-flight word is still captured and delivered, then no further rd_o.
